// File: rtl/execute_muldiv.sv
// Multi-cycle M-extension unit: registered multiplier plus a radix-2 restoring divider.
// Define MULDIV_DIV_EN to build the divider; without it, divide ops complete at once with illegal=1.
module execute_muldiv #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [REGW-1:0] rd_in,
    input  logic            flush,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic [REGW-1:0] rd_out,
    output logic            busy,
    output logic            illegal
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
`ifdef MULDIV_DIV_EN
    localparam logic [1:0] S_DIV  = 2'd2;
`endif
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] op_a_q, op_a_d;
    logic [XLEN-1:0] op_b_q, op_b_d;
    logic [1:0]      fn_q, fn_d;
    logic [REGW-1:0] rd_pend_q, rd_pend_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [REGW-1:0] rd_out_q, rd_out_d;
    logic            illegal_q, illegal_d;

    logic              accept;
    logic              a_sign, b_sign;
    logic [2*XLEN-1:0] a_ext, b_ext, product;

`ifdef MULDIV_DIV_EN
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [CW-1:0]   count_q, count_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;

    logic            in_signed, sa, sb, div_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b, special_res;
    logic [XLEN:0]   rem_sh, diff;
    logic [XLEN-1:0] rem_nx, quo_nx, q_fix, r_fix;
`endif

    assign accept    = in_valid && (state_q == S_IDLE) && !flush;
    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE) && !flush;
    assign result    = result_q;
    assign rd_out    = rd_out_q;
    assign illegal   = illegal_q && out_valid;

    // fn_q[1:0]: 00 MUL, 01 MULH (s*s), 10 MULHSU (s*u), 11 MULHU (u*u)
    assign a_sign  = (fn_q != 2'b11);
    assign b_sign  = !fn_q[1];
    assign a_ext   = {{XLEN{a_sign & op_a_q[XLEN-1]}}, op_a_q};
    assign b_ext   = {{XLEN{b_sign & op_b_q[XLEN-1]}}, op_b_q};
    assign product = a_ext * b_ext;

`ifdef MULDIV_DIV_EN
    assign in_signed = !funct3[0];
    assign sa        = in_signed & rs1_val[XLEN-1];
    assign sb        = in_signed & rs2_val[XLEN-1];
    assign mag_a     = sa ? -rs1_val : rs1_val;
    assign mag_b     = sb ? -rs2_val : rs2_val;
    assign div_zero  = (rs2_val == '0);
    assign div_ovf   = in_signed && (rs1_val == MIN_NEG) && (rs2_val == '1);

    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = funct3[1] ? rs1_val : '1;
        end else if (div_ovf) begin
            special_res = funct3[1] ? '0 : rs1_val;
        end
    end

    // One restoring step: shift in the next dividend bit, keep the trial difference if it did not borrow.
    assign rem_sh = {rem_q, quo_q[XLEN-1]};
    assign diff   = rem_sh - {1'b0, op_b_q};
    assign rem_nx = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_nx = {quo_q[XLEN-2:0], ~diff[XLEN]};
    assign q_fix  = neg_quo_q ? -quo_nx : quo_nx;
    assign r_fix  = neg_rem_q ? -rem_nx : rem_nx;
`endif

    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        fn_d      = fn_q;
        rd_pend_d = rd_pend_q;
        result_d  = result_q;
        rd_out_d  = rd_out_q;
        illegal_d = illegal_q;
`ifdef MULDIV_DIV_EN
        quo_d     = quo_q;
        rem_d     = rem_q;
        count_d   = count_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
`endif
        if (flush && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_a_d    = rs1_val;
                        op_b_d    = rs2_val;
                        fn_d      = funct3[1:0];
                        rd_pend_d = rd_in;
                        if (!funct3[2]) begin
                            state_d = S_MUL;
                        end else begin
`ifdef MULDIV_DIV_EN
                            if (div_zero || div_ovf) begin
                                result_d  = special_res;
                                rd_out_d  = rd_in;
                                illegal_d = 1'b0;
                                state_d   = S_DONE;
                            end else begin
                                quo_d     = mag_a;
                                rem_d     = '0;
                                op_b_d    = mag_b;
                                count_d   = '0;
                                neg_quo_d = sa ^ sb;
                                neg_rem_d = sa;
                                state_d   = S_DIV;
                            end
`else
                            result_d  = '0;
                            rd_out_d  = rd_in;
                            illegal_d = 1'b1;
                            state_d   = S_DONE;
`endif
                        end
                    end
                end
                S_MUL: begin
                    result_d  = (fn_q == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
                    rd_out_d  = rd_pend_q;
                    illegal_d = 1'b0;
                    state_d   = S_DONE;
                end
`ifdef MULDIV_DIV_EN
                S_DIV: begin
                    quo_d   = quo_nx;
                    rem_d   = rem_nx;
                    count_d = count_q + 1'b1;
                    if (count_q == CW'(XLEN - 1)) begin
                        result_d  = fn_q[1] ? r_fix : q_fix;
                        rd_out_d  = rd_pend_q;
                        illegal_d = 1'b0;
                        state_d   = S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_a_q    <= '0;
            op_b_q    <= '0;
            fn_q      <= '0;
            rd_pend_q <= '0;
            result_q  <= '0;
            rd_out_q  <= '0;
            illegal_q <= 1'b0;
`ifdef MULDIV_DIV_EN
            quo_q     <= '0;
            rem_q     <= '0;
            count_q   <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            fn_q      <= fn_d;
            rd_pend_q <= rd_pend_d;
            result_q  <= result_d;
            rd_out_q  <= rd_out_d;
            illegal_q <= illegal_d;
`ifdef MULDIV_DIV_EN
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            count_q   <= count_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end
endmodule

// File: tb/tb_execute_muldiv.sv
// Directed bench for execute_muldiv; covers the divider when MULDIV_DIV_EN is defined, the illegal path otherwise.
module tb_execute_muldiv;
    localparam int XLEN = 32;
    localparam int REGW = 5;
    localparam int LAT_MUL  = 2;
    localparam int LAT_SPEC = 1;
    localparam int LAT_DIV  = XLEN + 1;
    localparam int MAX_WAIT = XLEN + 20;
`ifdef MULDIV_DIV_EN
    localparam logic [2:0] ABORT_F3   = 3'b100;
    localparam int         ABORT_WAIT = 8;
    localparam int         RST_WAIT   = 3;
`else
    localparam logic [2:0] ABORT_F3   = 3'b000;
    localparam int         ABORT_WAIT = 0;
    localparam int         RST_WAIT   = 0;
`endif

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [REGW-1:0] rd_in;
    logic            flush;
    logic            out_valid;
    logic [XLEN-1:0] result;
    logic [REGW-1:0] rd_out;
    logic            busy;
    logic            illegal;

    int n_checks = 0;
    int n_fail   = 0;
    logic [XLEN-1:0] exp_q[$];

    execute_muldiv #(.XLEN(XLEN), .REGW(REGW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in),
        .flush(flush), .out_valid(out_valid), .result(result), .rd_out(rd_out),
        .busy(busy), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one op, then require out_valid exactly lat edges after (and including) the acceptance edge.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [REGW-1:0] rd, input int lat,
                          input logic [XLEN-1:0] exp_res, input logic exp_ill);
        int n;
        logic [XLEN-1:0] e;
        exp_q.push_back(exp_res);
        @(negedge clk);
        in_valid = 1'b1; funct3 = f3; rs1_val = a; rs2_val = b; rd_in = rd;
        check({tag, ".in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; rs1_val = $urandom; rs2_val = $urandom; rd_in = REGW'($urandom_range(0, 31));
        check({tag, ".busy"}, busy, 1);
        check({tag, ".in_ready_busy"}, in_ready, 0);
        n = 1;
        while (!out_valid && n < MAX_WAIT) begin
            @(posedge clk); #1;
            n++;
        end
        e = exp_q.pop_front();
        check({tag, ".latency"}, n, lat);
        check({tag, ".out_valid"}, out_valid, 1);
        check({tag, ".result"}, result, e);
        check({tag, ".rd_out"}, rd_out, rd);
        check({tag, ".illegal"}, illegal, exp_ill);
        @(posedge clk); #1;
        check({tag, ".strobe_end"}, out_valid, 0);
        check({tag, ".idle"}, busy, 0);
    endtask

    task automatic watch_quiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; funct3 = '0;
        rs1_val = '0; rs2_val = '0; rd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.in_ready", in_ready, 1);
        check("rst.busy", busy, 0);
        check("rst.out_valid", out_valid, 0);
        check("rst.result", result, 0);
        check("rst.rd_out", rd_out, 0);
        check("rst.illegal", illegal, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mul_7x-3",  3'b000, 32'd7, 32'hFFFF_FFFD, 5'd1, LAT_MUL, 32'hFFFF_FFEB, 1'b0);
        run_op("mulh_7x-3", 3'b001, 32'd7, 32'hFFFF_FFFD, 5'd2, LAT_MUL, 32'hFFFF_FFFF, 1'b0);
        run_op("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, LAT_MUL, 32'hFFFF_FFFE, 1'b0);
        run_op("mulhsu_-1x2", 3'b010, 32'hFFFF_FFFF, 32'd2, 5'd4, LAT_MUL, 32'hFFFF_FFFF, 1'b0);
        run_op("mulh_min2", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd5, LAT_MUL, 32'h4000_0000, 1'b0);
        run_op("mulhu_big", 3'b011, 32'h8000_0000, 32'd4, 5'd6, LAT_MUL, 32'h0000_0002, 1'b0);
        run_op("mul_9x3",   3'b000, 32'd9, 32'd3, 5'd7, LAT_MUL, 32'd27, 1'b0);

`ifdef MULDIV_DIV_EN
        run_op("div_-7/2",   3'b100, 32'hFFFF_FFF9, 32'd2, 5'd8,  LAT_DIV, 32'hFFFF_FFFD, 1'b0);
        run_op("rem_-7/2",   3'b110, 32'hFFFF_FFF9, 32'd2, 5'd9,  LAT_DIV, 32'hFFFF_FFFF, 1'b0);
        run_op("divu_100/7", 3'b101, 32'd100, 32'd7, 5'd10, LAT_DIV, 32'd14, 1'b0);
        run_op("remu_100/7", 3'b111, 32'd100, 32'd7, 5'd11, LAT_DIV, 32'd2, 1'b0);
        run_op("div_7/-2",   3'b100, 32'd7, 32'hFFFF_FFFE, 5'd12, LAT_DIV, 32'hFFFF_FFFD, 1'b0);
        run_op("rem_7/-2",   3'b110, 32'd7, 32'hFFFF_FFFE, 5'd13, LAT_DIV, 32'd1, 1'b0);
        run_op("remu_big",   3'b111, 32'hFFFF_FFFF, 32'h10, 5'd14, LAT_DIV, 32'hF, 1'b0);
        run_op("divu_5/0",   3'b101, 32'd5, 32'd0, 5'd15, LAT_SPEC, 32'hFFFF_FFFF, 1'b0);
        run_op("rem_5/0",    3'b110, 32'd5, 32'd0, 5'd16, LAT_SPEC, 32'd5, 1'b0);
        run_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, LAT_SPEC, 32'h8000_0000, 1'b0);
        run_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, LAT_SPEC, 32'd0, 1'b0);
`else
        run_op("div_9/3_ill",  3'b100, 32'd9, 32'd3, 5'd8,  LAT_SPEC, 32'd0, 1'b1);
        run_op("remu_9/3_ill", 3'b111, 32'd9, 32'd3, 5'd9,  LAT_SPEC, 32'd0, 1'b1);
        run_op("divu_5/0_ill", 3'b101, 32'd5, 32'd0, 5'd10, LAT_SPEC, 32'd0, 1'b1);
`endif
        run_op("mul_9x3_b", 3'b000, 32'd9, 32'd3, 5'd19, LAT_MUL, 32'd27, 1'b0);

        // Flush asserted with in_valid in IDLE must not accept.
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; funct3 = 3'b000; rs1_val = 32'd2; rs2_val = 32'd2; rd_in = 5'd20;
        @(posedge clk); #1;
        check("idle_flush.busy", busy, 0);
        in_valid = 1'b0; flush = 1'b0;
        watch_quiet("idle_flush.quiet", 4);

        // Abort an in-flight op with flush.
        @(negedge clk);
        in_valid = 1'b1; funct3 = ABORT_F3; rs1_val = 32'hFFFF_FFF9; rs2_val = 32'd2; rd_in = 5'd21;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (ABORT_WAIT) @(posedge clk);
        #1;
        check("flush.busy_before", busy, 1);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        check("flush.busy_after", busy, 0);
        check("flush.out_valid", out_valid, 0);
        flush = 1'b0;
        watch_quiet("flush.quiet", XLEN + 8);
        check("flush.result_hold", result, 27);
        check("flush.rd_hold", rd_out, 19);
        run_op("mul_after_flush", 3'b000, 32'd6, 32'd7, 5'd22, LAT_MUL, 32'd42, 1'b0);

        // Flush during DONE suppresses the strobe in that cycle.
        @(negedge clk);
        in_valid = 1'b1; funct3 = 3'b000; rs1_val = 32'd3; rs2_val = 32'd5; rd_in = 5'd23;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("done_flush.pre", out_valid, 1);
        flush = 1'b1;
        #1;
        check("done_flush.out_valid", out_valid, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        check("done_flush.idle", busy, 0);
        watch_quiet("done_flush.quiet", 3);

        // Synchronous reset in the middle of an op.
        @(negedge clk);
        in_valid = 1'b1; funct3 = ABORT_F3; rs1_val = 32'd100; rs2_val = 32'd7; rd_in = 5'd24;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (RST_WAIT) @(posedge clk);
        #1;
        check("midrst.busy_before", busy, 1);
        @(negedge clk);
        rst_n = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        check("midrst.busy", busy, 0);
        check("midrst.in_ready", in_ready, 1);
        check("midrst.out_valid", out_valid, 0);
        check("midrst.result", result, 0);
        check("midrst.rd_out", rd_out, 0);
        check("midrst.illegal", illegal, 0);
        @(negedge clk);
        rst_n = 1'b1; flush = 1'b0;
        watch_quiet("midrst.quiet", XLEN + 8);
        run_op("mul_after_rst", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd25, LAT_MUL, 32'd1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/execute_muldiv.md
# execute_muldiv

Parametrised multi-cycle M-extension unit for the execute stage. It accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operation at a time using forwarded operands, and computes the result with a registered multiplier or an iterative radix-2 divider. While busy it stalls the decode/execute boundary, and it returns the result with its destination register for the memory stage. Unlike the single-cycle ALU path, it has variable latency, a ready/valid handshake and flush abort.

## Interface
Parameters:
- XLEN, 32: operand and result width; must be even and at least 8.
- REGW, 5: destination register index width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operation offered; qualified by v_de in the execute stage.
- in_ready  out  1  unit can accept; equals state==IDLE.
- funct3  in  3  M-extension funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_val  in  XLEN  forwarded operand A.
- rs2_val  in  XLEN  forwarded operand B.
- rd_in  in  REGW  destination register.
- flush  in  1  pipeline flush; aborts any operation.
- out_valid  out  1  one-cycle result strobe.
- result  out  XLEN  result; meaningful only when out_valid is high.
- rd_out  out  REGW  destination register for the result.
- busy  out  1  state!=IDLE; drives the execute-stage stall.
- illegal  out  1  set together with out_valid when a divide op is issued and divide is compiled out.

## Operation
- An operation is accepted on a rising edge where in_valid && in_ready && !flush. At that edge the operands, funct3 and rd_in are latched.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - Accept a mul op: go to MUL.
  - Accept a divide special case: write the result and go straight to DONE.
  - Accept any other divide op: go to DIV, with count=0 and operands loaded as magnitudes.
- MUL: one cycle. Compute the 2*XLEN product from the operands sign-extended or zero-extended per funct3.
  - MUL returns product[XLEN-1:0].
  - MULH, MULHSU and MULHU return product[2XLEN-1:XLEN].
  - The result is registered and the state goes to DONE.
- DIV: restoring shift-subtract, one quotient bit per cycle.
  - After XLEN iterations, apply the sign fixup: quotient sign is sA^sB; remainder sign is sA.
  - Write quotient (DIV/DIVU) or remainder (REM/REMU) to result and go to DONE.
- Divide special cases, applied at acceptance:
  - Divide by zero: quotient is all ones; remainder is rs1_val.
  - Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1): quotient is rs1_val; remainder is 0.
- DONE: out_valid=1 for exactly one cycle, then go to IDLE. A new op cannot be accepted in DONE.
- flush in any non-IDLE state: the next state is IDLE, no out_valid occurs, and the partial result is discarded. A flush asserted during DONE suppresses out_valid in that same cycle (out_valid = DONE && !flush).
- result and rd_out hold their value until the next completion.

## Timing
- Reset (rst_n low at an edge): state=IDLE, count=0, result=0, rd_out=0, illegal=0. After reset, out_valid=0, busy=0, in_ready=1.
- Latency from the acceptance edge T to the out_valid cycle:
  - MUL family: T+2.
  - Divide special case: T+1.
  - Regular divide: T+XLEN+1 (T+33 at XLEN=32).
- Throughput is one op per latency+1 cycles, because IDLE is revisited between operations.
- Reset during any state overrides flush and in_valid.
- in_ready and busy are combinational from state only, with no path from in_valid.

## Configuration
- MULDIV_DIV_EN defined: full divider as above.
- MULDIV_DIV_EN undefined:
  - No divider hardware and no DIV state.
  - An accepted divide op goes to DONE with result=0 and illegal=1 (latency T+1).
  - The MUL family is unchanged.

## Test plan
- MUL 7 * -3 (XLEN=32), accepted at T -> out_valid at T+2, result=0xFFFFFFEB; MULH of the same operands -> 0xFFFFFFFF.
- MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF(-1) * 2 -> 0xFFFFFFFF.
- DIV -7 / 2 -> out_valid at T+33, result 0xFFFFFFFD. REM of the same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- DIVU 5 / 0 -> T+1, result 0xFFFFFFFF; REM 5 / 0 -> 5. DIV 0x80000000 / -1 -> 0x80000000; REM of the same operands -> 0.
- Start DIV, assert flush at T+10 -> busy low at T+11, no out_valid. A MUL accepted afterwards completes normally. rst_n low at T+5 of a DIV -> same abort, all outputs at reset values.
- Build without MULDIV_DIV_EN: DIV 9 / 3 -> T+1 out_valid, result 0, illegal=1. MUL 9 * 3 -> 27, illegal=0.
